commutation_sequencer: RTL

- Sequences the three-phase BLDC commutation datapath by generating its `cycle_position` (electrical angle, 0..1169) and `gain` inputs.
- Runs start-up rotor alignment, acceleration-limited velocity ramps, steady run and controlled stop.
- Sits between the velocity control loop (source of `velocity_cmd`) and the commutation/PWM block.

---
 rtl/commutation_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/commutation_sequencer.sv
// commutation_sequencer
//   Produces the electrical angle (cycle_position) and drive gain for the
//   three-phase BLDC commutation/PWM block. Runs rotor alignment,
//   acceleration-limited velocity ramps, steady run and controlled stop.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low; clears all state and outputs
//   start          single-cycle run request (honoured only when idle)
//   stop           single-cycle ramp-down request (wins over start)
//   velocity_cmd   signed target velocity, steps/tick * 2^-FRAC_BITS
//   accel_step     maximum velocity change per tick, same units
//   run_gain       gain driven during RAMP/RUN/STOP
//   align_gain     gain driven during ALIGN
//   cycle_position integer electrical position, 0..CYCLE_STEPS-1
//   gain           gain to the commutation block
//   enable, busy   high whenever the sequencer is not idle
//   at_speed       high in RUN
module commutation_sequencer #(
    parameter int unsigned CYCLE_STEPS = 1170,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned UPDATE_DIV  = 1024,
    parameter int unsigned ALIGN_TICKS = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic signed [15:0] velocity_cmd,
    input  logic        [7:0]  accel_step,
    input  logic        [9:0]  run_gain,
    input  logic        [9:0]  align_gain,
    output logic        [10:0] cycle_position,
    output logic        [9:0]  gain,
    output logic               enable,
    output logic               at_speed,
    output logic               busy
);

    localparam int unsigned ACC_W = 11 + FRAC_BITS;
    localparam int unsigned CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam int unsigned AL_W  = $clog2(ALIGN_TICKS + 1);
    localparam logic signed [ACC_W:0] WRAP_LEN = (ACC_W + 1)'(CYCLE_STEPS << FRAC_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_RAMP,
        S_RUN,
        S_STOP
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic [AL_W-1:0]    align_cnt;
    logic [AL_W-1:0]    align_nx;
    logic signed [15:0] vel;
    logic signed [15:0] vel_nx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nx;

    logic signed [15:0]  cmd_sat;
    logic signed [15:0]  target;
    logic signed [16:0]  diff;
    logic signed [16:0]  accel_ext;
    logic signed [16:0]  vel_up;
    logic signed [16:0]  vel_dn;
    logic signed [15:0]  vel_step;
    logic signed [ACC_W:0] acc_sum;
    logic signed [ACC_W:0] acc_fix;
    logic [ACC_W-1:0]    acc_wrap;

    assign tick = (tick_cnt == CNT_W'(UPDATE_DIV - 1));

    // -32768 has no positive counterpart; clamp so ramps stay symmetric.
    assign cmd_sat   = (velocity_cmd == 16'sh8000) ? 16'sh8001 : velocity_cmd;
    assign target    = (state == S_STOP) ? 16'sd0 : cmd_sat;
    assign diff      = {target[15], target} - {vel[15], vel};
    assign accel_ext = {9'd0, accel_step};
    assign vel_up    = {vel[15], vel} + accel_ext;
    assign vel_dn    = {vel[15], vel} - accel_ext;

    // Step toward target, landing exactly on it when within one step.
    always_comb begin
        vel_step = target;
        if (diff > accel_ext) begin
            vel_step = vel_up[15:0];
        end else if (diff < -accel_ext) begin
            vel_step = vel_dn[15:0];
        end
    end

    // Old velocity advances the position; a single wrap correction suffices
    // because |vel| is far below one electrical cycle.
    assign acc_sum = $signed({1'b0, acc}) + $signed({{(ACC_W - 15){vel[15]}}, vel});

    always_comb begin
        acc_fix = acc_sum;
        if (acc_sum >= WRAP_LEN) begin
            acc_fix = acc_sum - WRAP_LEN;
        end else if (acc_sum[ACC_W]) begin
            acc_fix = acc_sum + WRAP_LEN;
        end
    end

    assign acc_wrap = acc_fix[ACC_W-1:0];

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        vel_nx   = vel;
        align_nx = align_cnt;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nx = S_ALIGN;
                    acc_nx   = '0;
                    vel_nx   = '0;
                    align_nx = '0;
                end
            end
            S_ALIGN: begin
                acc_nx = '0;
                if (stop) begin
                    state_nx = S_IDLE;
                end else if (tick) begin
                    align_nx = align_cnt + 1'b1;
                    if (align_cnt == AL_W'(ALIGN_TICKS - 1)) begin
                        state_nx = S_RAMP;
                    end
                end
            end
            S_RAMP, S_RUN, S_STOP: begin
                if (tick) begin
                    acc_nx = acc_wrap;
                    vel_nx = vel_step;
                    if (state == S_RAMP && vel_step == cmd_sat) begin
                        state_nx = S_RUN;
                    end
                    if (state == S_RUN && vel != cmd_sat) begin
                        state_nx = S_RAMP;
                    end
                    if (state == S_STOP && vel_step == 16'sd0) begin
                        state_nx = S_IDLE;
                    end
                end
                if (stop && state != S_STOP) begin
                    state_nx = S_STOP;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            tick_cnt       <= '0;
            align_cnt      <= '0;
            vel            <= '0;
            acc            <= '0;
            cycle_position <= '0;
            gain           <= '0;
            enable         <= 1'b0;
            at_speed       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            tick_cnt       <= tick ? '0 : tick_cnt + 1'b1;
            state          <= state_nx;
            align_cnt      <= align_nx;
            vel            <= vel_nx;
            acc            <= acc_nx;
            cycle_position <= acc_nx[ACC_W-1:FRAC_BITS];
            if (state_nx == S_IDLE) begin
                gain <= '0;
            end else if (state_nx == S_ALIGN) begin
                gain <= align_gain;
            end else begin
                gain <= run_gain;
            end
            enable   <= (state_nx != S_IDLE);
            busy     <= (state_nx != S_IDLE);
            at_speed <= (state_nx == S_RUN);
        end
    end

endmodule
